// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature emitter and any matching receiver:
// FSM state encoding, phase-to-{a,b} Gray mapping and the phase step function.
package quad_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BOUNCE = 2'd1,
    S_HOLD   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // {a,b} for phase 0..3; adjacent phases differ in exactly one line
  localparam logic [1:0] GRAY_P0 = 2'b00;
  localparam logic [1:0] GRAY_P1 = 2'b01;
  localparam logic [1:0] GRAY_P2 = 2'b11;
  localparam logic [1:0] GRAY_P3 = 2'b10;

  function automatic logic [1:0] phase_to_ab(input logic [1:0] p);
    case (p)
      2'd0:    phase_to_ab = GRAY_P0;
      2'd1:    phase_to_ab = GRAY_P1;
      2'd2:    phase_to_ab = GRAY_P2;
      default: phase_to_ab = GRAY_P3;
    endcase
  endfunction

  // dir=1 increments, dir=0 decrements, both mod 4
  function automatic logic [1:0] next_phase(input logic [1:0] p, input logic dir);
    next_phase = dir ? (p + 2'd1) : (p - 2'd1);
  endfunction

endpackage

// File: rtl/quad_phase_gen.sv
// Phase register for the quadrature emitter.
//   clk, reset : clock / synchronous active-high reset (phase -> 0)
//   i_step     : advance the phase one step in direction i_dir
//   i_dir      : 1 = increment, 0 = decrement
//   o_ab       : {a,b} Gray code of the current phase
//   o_nxt_ab   : {a,b} Gray code of the phase one step away in direction i_dir
module quad_phase_gen
  import quad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  input  logic       i_dir,
  output logic [1:0] o_ab,
  output logic [1:0] o_nxt_ab
);

  logic [1:0] r_phase;

  always_ff @(posedge clk) begin
    if (reset)       r_phase <= 2'd0;
    else if (i_step) r_phase <= next_phase(r_phase, i_dir);
  end

  assign o_ab     = phase_to_ab(r_phase);
  assign o_nxt_ab = phase_to_ab(next_phase(r_phase, i_dir));

endmodule

// File: rtl/quad_emitter.sv
// Quadrature A/B transmitter driven by step commands, with optional
// contact-bounce injection ahead of each settled edge.
//   clk, reset            : clock / synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake (ready in IDLE and DONE)
//   cmd_dir/count/hold/bounce : direction, edge count, settled cycles per edge
//                           (0 -> 1), bounce pairs per edge
//   cmd_abort             : stop after settling the in-flight edge
//   a, b                  : registered quadrature outputs
//   busy, done            : command in progress / one-cycle completion pulse
//   edges_left            : remaining edges including the one in flight
module quad_emitter
  import quad_pkg::*;
#(
  parameter int COUNT_WIDTH  = 8,
  parameter int PERIOD_WIDTH = 16,
  parameter int BOUNCE_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_dir,
  input  logic [COUNT_WIDTH-1:0]  cmd_count,
  input  logic [PERIOD_WIDTH-1:0] cmd_hold,
  input  logic [BOUNCE_WIDTH-1:0] cmd_bounce,
  input  logic                    cmd_abort,
  output logic                    a,
  output logic                    b,
  output logic                    busy,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  edges_left
);

  // one down-counter serves both the bounce (2*bounce cycles) and hold phases
  localparam int CW = (PERIOD_WIDTH > BOUNCE_WIDTH + 1) ? PERIOD_WIDTH : BOUNCE_WIDTH + 1;

  state_t                  r_state, w_nxt_state;
  logic [CW-1:0]           r_cnt, w_nxt_cnt;
  logic [COUNT_WIDTH-1:0]  r_edges, w_nxt_edges;
  logic [1:0]              r_ab, w_nxt_ab;
  logic [1:0]              r_mask, w_nxt_mask;   // the line that changes on this edge
  logic                    r_dir;
  logic [PERIOD_WIDTH-1:0] r_hold;
  logic [BOUNCE_WIDTH-1:0] r_bounce;

  logic                    w_accept_st, w_dir, w_step, w_load, w_start;
  logic [1:0]              w_pg_ab, w_pg_nxt_ab;
  logic [BOUNCE_WIDTH-1:0] w_sb;
  logic [PERIOD_WIDTH-1:0] w_sh;

  // counter preload is "cycles - 1" since the load cycle itself is displayed
  function automatic logic [CW-1:0] hold_load(input logic [PERIOD_WIDTH-1:0] h);
    hold_load = (h == '0) ? '0 : CW'(h - PERIOD_WIDTH'(1));
  endfunction

  function automatic logic [CW-1:0] bounce_load(input logic [BOUNCE_WIDTH-1:0] n);
    bounce_load = CW'({n, 1'b0}) - CW'(1);
  endfunction

  assign w_accept_st = (r_state == S_IDLE) || (r_state == S_DONE);
  // the first edge of a command steps in the direction being offered
  assign w_dir       = w_accept_st ? cmd_dir : r_dir;

  quad_phase_gen u_phase (
    .clk      (clk),
    .reset    (reset),
    .i_step   (w_step),
    .i_dir    (w_dir),
    .o_ab     (w_pg_ab),
    .o_nxt_ab (w_pg_nxt_ab)
  );

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_edges = r_edges;
    w_nxt_ab    = r_ab;
    w_nxt_mask  = r_mask;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_start     = 1'b0;
    w_sb        = r_bounce;
    w_sh        = r_hold;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (r_state == S_DONE) w_nxt_state = S_IDLE;
        if (cmd_valid) begin
          w_load      = 1'b1;
          w_nxt_edges = cmd_count;
          w_sb        = cmd_bounce;
          w_sh        = cmd_hold;
          if (cmd_count == '0) w_nxt_state = S_DONE;
          else                 w_start     = 1'b1;
        end
      end
      default: begin  // S_BOUNCE, S_HOLD
        if (cmd_abort) begin
          // phase already holds the in-flight edge: show it settled and stop
          w_nxt_state = S_DONE;
          w_nxt_edges = '0;
          w_nxt_ab    = w_pg_ab;
        end else if (r_cnt != '0) begin
          w_nxt_cnt = r_cnt - CW'(1);
          if (r_state == S_BOUNCE) w_nxt_ab = r_ab ^ r_mask;
        end else if (r_state == S_BOUNCE) begin
          w_nxt_state = S_HOLD;
          w_nxt_cnt   = hold_load(r_hold);
          w_nxt_ab    = w_pg_ab;
        end else begin
          w_nxt_edges = (r_edges == '0) ? '0 : r_edges - COUNT_WIDTH'(1);
          if (r_edges <= COUNT_WIDTH'(1)) w_nxt_state = S_DONE;
          else                            w_start     = 1'b1;
        end
      end
    endcase
    // edge start: step phase, show the new code, remember which line moved
    if (w_start) begin
      w_step     = 1'b1;
      w_nxt_ab   = w_pg_nxt_ab;
      w_nxt_mask = w_pg_nxt_ab ^ w_pg_ab;
      if (w_sb != '0) begin
        w_nxt_state = S_BOUNCE;
        w_nxt_cnt   = bounce_load(w_sb);
      end else begin
        w_nxt_state = S_HOLD;
        w_nxt_cnt   = hold_load(w_sh);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_edges  <= '0;
      r_ab     <= 2'b00;
      r_mask   <= 2'b00;
      r_dir    <= 1'b0;
      r_hold   <= PERIOD_WIDTH'(1);
      r_bounce <= '0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_edges <= w_nxt_edges;
      r_ab    <= w_nxt_ab;
      r_mask  <= w_nxt_mask;
      if (w_load) begin
        r_dir    <= cmd_dir;
        r_hold   <= (cmd_hold == '0) ? PERIOD_WIDTH'(1) : cmd_hold;
        r_bounce <= cmd_bounce;
      end
    end
  end

  assign a          = r_ab[1];
  assign b          = r_ab[0];
  assign cmd_ready  = w_accept_st;
  assign busy       = (r_state == S_BOUNCE) || (r_state == S_HOLD);
  assign done       = (r_state == S_DONE);
  assign edges_left = r_edges;

endmodule

// File: tb/tb_quad_emitter.sv
module tb_quad_emitter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0, cmd_dir = 1'b0, cmd_abort = 1'b0;
  logic [7:0]  cmd_count = '0;
  logic [15:0] cmd_hold = '0;
  logic [3:0]  cmd_bounce = '0;
  logic        cmd_ready, a, b, busy, done;
  logic [7:0]  edges_left;

  int checks = 0, errors = 0;
  int p_model = 0;          // expected phase 0..3
  int mon_err = 0, enc = 0; // single-bit monitor and reference receiver count
  logic       rst_seen = 1'b1;
  logic [1:0] prev_ab = 2'b00;

  quad_emitter dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_hold(cmd_hold),
    .cmd_bounce(cmd_bounce), .cmd_abort(cmd_abort), .a(a), .b(b),
    .busy(busy), .done(done), .edges_left(edges_left)
  );

  always #5 clk = ~clk;

  // monitor: a/b never both change (reset excepted); track a matched receiver
  always @(posedge clk) rst_seen <= reset;
  always @(negedge clk) begin
    if (!rst_seen) begin
      if (prev_ab[1] != a && prev_ab[0] != b) mon_err <= mon_err + 1;
      if ((prev_ab == 2'b01 && {a,b} == 2'b11) || (prev_ab == 2'b10 && {a,b} == 2'b00)) enc <= enc + 1;
      if ((prev_ab == 2'b11 && {a,b} == 2'b01) || (prev_ab == 2'b00 && {a,b} == 2'b10)) enc <= enc - 1;
    end
    prev_ab <= {a,b};
  end

  function automatic logic [1:0] gray(input int p);
    case (p % 4)
      0: gray = 2'b00;
      1: gray = 2'b01;
      2: gray = 2'b11;
      default: gray = 2'b10;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [1:0] eab, input int ebusy,
                         input int edone, input int erdy, input int eedges);
    chk({tag, ".ab"}, 32'({a,b}), 32'(eab));
    chk({tag, ".busy"}, 32'(busy), 32'(ebusy));
    chk({tag, ".done"}, 32'(done), 32'(edone));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(erdy));
    chk({tag, ".edges"}, 32'(edges_left), 32'(eedges));
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Issue one command at the current negedge and follow it cycle by cycle.
  // ab_at / rs_at: cycle after acceptance at which abort / reset is driven (-1 none).
  task automatic do_cmd(input int d, input int cnt, input int hld, input int bnc,
                        input int ab_at, input int rs_at);
    int per, total, p0, e, o, np, op, stp;
    bit stop;
    logic [1:0] eab;
    chk("ready_pre", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_dir = d[0]; cmd_count = 8'(cnt);
    cmd_hold = 16'(hld); cmd_bounce = 4'(bnc); cmd_abort = 1'b0;
    tick();
    cmd_valid = 1'b0;
    stp   = d ? 1 : 3;
    per   = 2 * bnc + ((hld == 0) ? 1 : hld);
    total = cnt * per;
    p0    = p_model;
    stop  = 0;
    for (int k = 1; k <= total + 1 && !stop; k++) begin
      if (k <= total) begin
        e  = (k - 1) / per;
        o  = (k - 1) % per;
        np = (p0 + (e + 1) * stp) % 4;
        op = (np + 4 - stp) % 4;
        eab = (o < 2 * bnc && (o % 2) == 1) ? gray(op) : gray(np);
        chk_out("run", eab, 1, 0, 0, cnt - e);
        if (k == ab_at) begin
          cmd_abort = 1'b1;
          tick();
          cmd_abort = 1'b0;
          chk_out("abort", gray(np), 0, 1, 1, 0);
          p_model = np;
          stop = 1;
        end else if (k == rs_at) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          chk_out("reset_mid", 2'b00, 0, 0, 1, 0);
          p_model = 0;
          stop = 1;
        end else begin
          // offers while busy must be ignored
          cmd_valid  = 1'($urandom_range(0, 1));
          cmd_dir    = 1'($urandom_range(0, 1));
          cmd_count  = 8'($urandom_range(0, 255));
          cmd_hold   = 16'($urandom_range(0, 9));
          cmd_bounce = 4'($urandom_range(0, 15));
          tick();
          cmd_valid = 1'b0;
        end
      end else begin
        p_model = (p0 + cnt * stp) % 4;
        chk_out("done", gray(p_model), 0, 1, 1, 0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_abort = 1'($urandom_range(0, 1));  // ignored outside BOUNCE/HOLD
      tick();
      cmd_abort = 1'b0;
      chk_out("idle", gray(p_model), 0, 0, 1, 0);
    end
  endtask

  initial begin
    int c, h, bn, ab;
    reset = 1'b1;
    tick();
    tick();
    chk_out("reset", 2'b00, 0, 0, 1, 0);
    reset = 1'b0;
    idle(1);

    // four increment edges, hold 3: receiver sees +2
    do_cmd(1, 4, 3, 0, -1, -1);
    chk("enc_plus2", 32'(enc), 32'd2);
    idle(1);
    do_cmd(0, 2, 2, 2, -1, -1);          // decrement with bounce
    idle(1);
    do_cmd(1, 0, 5, 1, -1, -1);          // zero count: done next cycle
    idle(2);
    do_cmd(1, 10, 2, 2, 14, -1);         // abort inside 3rd edge bounce
    do_cmd(0, 3, 0, 1, -1, -1);          // offered in DONE cycle, hold=0
    do_cmd(1, 2, 0, 0, -1, -1);          // back-to-back again
    idle(1);
    do_cmd(1, 5, 4, 0, -1, 6);           // reset in 2nd edge HOLD
    idle(1);

    for (int i = 0; i < 25; i++) begin
      c  = $urandom_range(0, 12);
      h  = $urandom_range(0, 5);
      bn = $urandom_range(0, 3);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 40) : -1;
      do_cmd(int'($urandom_range(0, 1)), c, h, bn, ab, -1);
      idle($urandom_range(0, 2));
    end

    chk("single_bit", 32'(mon_err), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
